// File: rtl/key_scan_pkg.sv
// Shared types and constants for the washer front-panel keypad scanner.
// Key codes are {row_idx, col_idx} of the physical keypad position.
package key_scan_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam int         KEY_W     = 4;
    localparam int         CNT_W     = 5;

    localparam logic [KEY_W-1:0] KEY_START      = 4'h0;
    localparam logic [KEY_W-1:0] KEY_MODE       = 4'h1;
    localparam logic [KEY_W-1:0] KEY_LEVEL_UP   = 4'h2;
    localparam logic [KEY_W-1:0] KEY_TIME_UP    = 4'h3;
    localparam logic [KEY_W-1:0] KEY_PAUSE      = 4'h4;
    localparam logic [KEY_W-1:0] KEY_CANCEL     = 4'h5;
    localparam logic [KEY_W-1:0] KEY_LEVEL_DOWN = 4'h6;
    localparam logic [KEY_W-1:0] KEY_TIME_DOWN  = 4'h7;

    // Index of the lowest active-low column; 0 when none is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_cnt.sv
// Saturating debounce counter shared by the press and release phases.
// done reflects the count this cycle would reach, so acceptance lands on the same tick.
module key_debounce_cnt
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_d == CNT_W'(DEBOUNCE));

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, captures the first
// low column, debounces press and release, and emits one key event per press.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DEBOUNCE = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_tick,
    input  logic [COLS-1:0]  col_in,
    output logic [ROWS-1:0]  row_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    logic [COLS-1:0]  sync_q, col_s_q;
    state_t           state_q, state_d;
    logic [ROWS-1:0]  row_out_q, row_out_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;
    logic             cnt_clr, cnt_inc, cnt_done;
    logic             col_hit, rotate;

    key_debounce_cnt #(.DEBOUNCE(DEBOUNCE)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .done  (cnt_done)
    );

    // Only the captured column matters once a key is being tracked.
    assign col_hit = ~col_s_q[col_idx_q];

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        rotate      = 1'b0;
        if (scan_tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!(&col_s_q)) begin
                        col_idx_d = lowest_low(col_s_q);
                        cnt_clr   = 1'b1;
                        state_d   = PRESS_DB;
                    end else begin
                        rotate = 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (col_hit) begin
                        cnt_inc = 1'b1;
                        if (cnt_done) begin
                            key_code_d  = {row_idx_q, col_idx_q};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        rotate  = 1'b1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!col_hit) begin
                        cnt_clr = 1'b1;
                        state_d = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (!col_hit) begin
                        cnt_inc = 1'b1;
                        if (cnt_done) begin
                            key_down_d = 1'b0;
                            rotate     = 1'b1;
                            state_d    = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        row_out_d = rotate ? {row_out_q[ROWS-2:0], row_out_q[ROWS-1]} : row_out_q;
        if (rotate) row_idx_d = row_idx_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q      <= '1;
            col_s_q     <= '1;
            state_q     <= SCAN;
            row_out_q   <= ROW_RESET;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            sync_q      <= col_in;
            col_s_q     <= sync_q;
            state_q     <= state_d;
            row_out_q   <= row_out_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: doc/key_scan.md
# key_scan

Matrix keypad scanner for the washer front panel, the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad row low at a time on a slow scan strobe, samples the column lines, and debounces both press and release. Each accepted press produces a single-cycle key event carrying a 4-bit key code, which the washer control FSM consumes (start, mode, water level, time setting).

## Interface
- `ROWS`, 4, number of keypad rows (fixed 4 in this revision)
- `COLS`, 4, number of keypad columns (fixed 4 in this revision)
- `DEBOUNCE`, 20, consecutive scan ticks required to accept a press or a release (≥2)

- `clk`  in  1  system clock, the only clock
- `reset`  in  1  synchronous, active-low reset
- `scan_tick`  in  1  one-`clk`-wide enable strobe (~1 kHz); all scan/debounce activity advances only on it
- `col_in`  in  COLS  column lines, active-low, externally pulled up, asynchronous
- `row_out`  out  ROWS  row drives, active-low, exactly one bit low at any time
- `key_code`  out  4  `{row_idx[1:0], col_idx[1:0]}` of the last accepted key
- `key_valid`  out  1  one-`clk` pulse when a press is accepted
- `key_down`  out  1  level, high from accept until debounced release

## Operation
- `col_in` passes through a 2-flop synchronizer; all decisions use the synchronized value `col_s`.
- States: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN, on `scan_tick`:
  - if `col_s` has any bit low: capture `row_idx` of the driven row and `col_idx` = lowest-index low column, hold `row_out`, clear counter, go PRESS_DB;
  - else rotate the driven row 1110 → 1101 → 1011 → 0111 → 1110.
- PRESS_DB, on `scan_tick`:
  - captured column low: counter+1; when the counter reaches `DEBOUNCE`, load `key_code`, pulse `key_valid`, set `key_down`, go HELD;
  - captured column high: go SCAN and rotate the row on the same tick.
- HELD, on `scan_tick`: captured column high → clear counter, go RELEASE_DB; otherwise stay. No auto-repeat.
- RELEASE_DB, on `scan_tick`:
  - captured column high: counter+1; at `DEBOUNCE`, clear `key_down`, go SCAN, rotate the row;
  - captured column low: go HELD.
- Other columns, and other rows, are ignored from capture until the return to SCAN. A second key pressed while one is held produces no event.
- Multiple columns low at capture: lowest index wins.
- Counter is 5 bits, saturating, compared with `==DEBOUNCE`. It never wraps.

## Timing
- Reset values: `row_out`=4'b1110, `key_code`=4'h0, `key_valid`=0, `key_down`=0, state SCAN, counter 0, synchronizer flops all ones.
- `reset` low dominates `scan_tick` in the same cycle. Reset mid-press drops `key_down` on the next `clk` and emits no event.
- Without `scan_tick`, no state, counter or output changes. The only exception is `key_valid`, which falls one `clk` after it rises.
- Press latency: `key_valid` and `key_down` rise in the cycle after the `scan_tick` that delivers the `DEBOUNCE`-th consecutive low sample. The capture tick counts as sample 0 and is not counted.
- Release latency: `key_down` falls in the cycle after the `DEBOUNCE`-th consecutive high sample in RELEASE_DB.
- `key_code` changes only with `key_valid` and holds until the next accepted press.
- `col_in` to `col_s`: 2 `clk`.

## Structure
- `key_scan_pkg`: state enum, `ROW_RESET`=4'b1110, `KEY_W`=4, and key-code constants for the washer keys (START=4'h0, MODE=4'h1, LEVEL_UP=4'h2, TIME_UP=4'h3, ...).
- One sub-module, `key_debounce_cnt`: saturating counter with `clr`, `inc` and `done` (`==DEBOUNCE`), instantiated once and shared by press and release phases.

## Test plan
- Reset, then 8 idle ticks → `row_out` sequence 1110, 1101, 1011, 0111, 1110, …; `key_valid` never asserts.
- `DEBOUNCE`=4, hold col 2 low while row 1 is driven → exactly one `key_valid`, `key_code`=4'h6, `key_down`=1 one cycle after the 4th counted tick.
- Bounce: column low for 2 ticks, high for 1, then low for 4 → single event only after the final 4; `row_out` resumes rotation after the high tick.
- Hold key 4'hF (row 3, col 3) for 50 ticks, then release with 2-tick bounce → one `key_valid`; `key_down` falls only after 4 consecutive high ticks.
- Press row 0 col 1 and col 3 simultaneously → `key_code`=4'h1. Pressing 4'h5 while 4'h1 is held → no second event.
- Assert `reset` low during PRESS_DB at count 3 → next `clk` all outputs at reset values, no `key_valid`. Reset coinciding with `scan_tick` → reset wins.
